// File: rtl/model_precedence_weighting_pkg.sv
// Shared DNC memory-stage definitions: FSM states, control levels, float constants
// and the adder operation codes used by the precedence weighting block.
package model_precedence_weighting_pkg;

    typedef enum logic [2:0] {
        STARTER,
        W_INPUT,
        W_ADD,
        SCALE,
        P_INPUT,
        P_MUL,
        P_ADD
    } state_t;

    localparam logic ZERO_DATA = 1'b0;
    localparam logic ONE_DATA  = 1'b1;

    localparam logic [63:0] FLOAT_ONE_64 = 64'h3FF0000000000000;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;

    // Exponent field width of the IEEE-754 format matching a scalar width.
    function automatic int unsigned float_exp_width(input int unsigned data_size);
        if (data_size == 16) return 5;
        if (data_size == 32) return 8;
        return 11;
    endfunction

endpackage

// File: rtl/model_scalar_float_adder.sv
// IEEE-754 scalar adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// One-cycle latency: result and READY appear the cycle after START.
module model_scalar_float_adder
    import model_precedence_weighting_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [CONTROL_SIZE-1:0] OPERATION,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic                    READY,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    localparam int unsigned EXP_W   = float_exp_width(DATA_SIZE);
    localparam int unsigned MW      = DATA_SIZE - EXP_W;
    localparam int unsigned XW      = MW + 3;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    logic [DATA_SIZE-1:0] b_adj, hi, lo, result_c;
    logic                 sign_hi, sign_lo;
    logic [EXP_W-1:0]     exp_hi, exp_lo, diff;
    logic [MW-1:0]        man_hi, man_lo, man_f;
    logic [XW-1:0]        x_hi, x_lo, x_sh, norm;
    logic [XW:0]          sum;
    logic signed [EW-1:0] exp_r;
    logic [MW:0]          man_r;
    int unsigned          lead;

    always_comb begin
        // Order operands by magnitude so the smaller one is the one aligned right.
        b_adj = {DATA_B_IN[DATA_SIZE-1] ^ (OPERATION == CONTROL_SIZE'(OP_SUB)), DATA_B_IN[DATA_SIZE-2:0]};
        if (b_adj[DATA_SIZE-2:0] > DATA_A_IN[DATA_SIZE-2:0]) begin
            hi = b_adj;
            lo = DATA_A_IN;
        end else begin
            hi = DATA_A_IN;
            lo = b_adj;
        end
        sign_hi = hi[DATA_SIZE-1];
        sign_lo = lo[DATA_SIZE-1];
        exp_hi  = hi[DATA_SIZE-2 -: EXP_W];
        exp_lo  = lo[DATA_SIZE-2 -: EXP_W];
        man_hi  = (exp_hi != '0) ? {1'b1, hi[MW-2:0]} : '0;
        man_lo  = (exp_lo != '0) ? {1'b1, lo[MW-2:0]} : '0;
        diff    = exp_hi - exp_lo;
        x_hi    = {man_hi, 3'b000};
        x_lo    = {man_lo, 3'b000};

        if (diff >= EXP_W'(XW)) begin
            x_sh    = '0;
            x_sh[0] = |man_lo;
        end else begin
            x_sh    = x_lo >> diff;
            x_sh[0] = x_sh[0] | (|(x_lo & ((XW'(1) << diff) - XW'(1))));
        end

        sum = (sign_hi == sign_lo) ? ({1'b0, x_hi} + {1'b0, x_sh})
                                   : ({1'b0, x_hi} - {1'b0, x_sh});

        lead = 0;
        for (int unsigned i = 0; i < XW; i++) begin
            if (sum[i]) lead = i;
        end

        exp_r = $signed({2'b00, exp_hi});
        if (sum[XW]) begin
            norm  = {sum[XW:2], sum[1] | sum[0]};
            exp_r = exp_r + $signed(EW'(1));
        end else begin
            norm  = sum[XW-1:0] << (XW - 1 - lead);
            exp_r = exp_r - $signed(EW'(XW - 1 - lead));
        end

        man_r = {1'b0, norm[XW-1:3]} + (MW+1)'(norm[2] & (norm[1] | norm[0] | norm[3]));
        man_f = man_r[MW] ? man_r[MW:1] : man_r[MW-1:0];
        if (man_r[MW]) exp_r = exp_r + $signed(EW'(1));

        // Missing hidden bit means an exact zero (or flushed underflow).
        if (!man_f[MW-1] || exp_r < $signed(EW'(1)))
            result_c = {sign_hi & sign_lo, {(DATA_SIZE-1){1'b0}}};
        else if (exp_r >= $signed(EW'(EXP_MAX)))
            result_c = {sign_hi, {EXP_W{1'b1}}, {(MW-1){1'b0}}};
        else
            result_c = {sign_hi, exp_r[EXP_W-1:0], man_f[MW-2:0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READY    <= 1'b0;
            DATA_OUT <= '0;
        end else begin
            READY <= START;
            if (START) DATA_OUT <= result_c;
        end
    end

endmodule

// File: rtl/model_scalar_float_multiplier.sv
// IEEE-754 scalar multiplier, round-to-nearest-even, subnormals flushed to zero.
// One-cycle latency: result and READY appear the cycle after START.
module model_scalar_float_multiplier
    import model_precedence_weighting_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic                 READY,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int unsigned EXP_W   = float_exp_width(DATA_SIZE);
    localparam int unsigned MW      = DATA_SIZE - EXP_W;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    logic                 sign_c, guard, sticky;
    logic [EXP_W-1:0]     exp_a, exp_b;
    logic [MW-1:0]        man_a, man_b, man_t, man_f;
    logic [2*MW-1:0]      prod;
    logic [MW:0]          man_r;
    logic signed [EW-1:0] exp_r;
    logic [DATA_SIZE-1:0] result_c;

    always_comb begin
        sign_c = DATA_A_IN[DATA_SIZE-1] ^ DATA_B_IN[DATA_SIZE-1];
        exp_a  = DATA_A_IN[DATA_SIZE-2 -: EXP_W];
        exp_b  = DATA_B_IN[DATA_SIZE-2 -: EXP_W];
        man_a  = (exp_a != '0) ? {1'b1, DATA_A_IN[MW-2:0]} : '0;
        man_b  = (exp_b != '0) ? {1'b1, DATA_B_IN[MW-2:0]} : '0;
        prod   = (2*MW)'(man_a) * (2*MW)'(man_b);
        exp_r  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(EW'(BIAS));

        // Product of two [1,2) mantissas lies in [1,4): renormalise by at most one.
        if (prod[2*MW-1]) begin
            man_t  = prod[2*MW-1:MW];
            guard  = prod[MW-1];
            sticky = |prod[MW-2:0];
            exp_r  = exp_r + $signed(EW'(1));
        end else begin
            man_t  = prod[2*MW-2:MW-1];
            guard  = prod[MW-2];
            sticky = |prod[MW-3:0];
        end

        man_r = {1'b0, man_t} + (MW+1)'(guard & (sticky | man_t[0]));
        man_f = man_r[MW] ? man_r[MW:1] : man_r[MW-1:0];
        if (man_r[MW]) exp_r = exp_r + $signed(EW'(1));

        if (!man_f[MW-1] || exp_r < $signed(EW'(1)))
            result_c = {sign_c, {(DATA_SIZE-1){1'b0}}};
        else if (exp_r >= $signed(EW'(EXP_MAX)))
            result_c = {sign_c, {EXP_W{1'b1}}, {(MW-1){1'b0}}};
        else
            result_c = {sign_c, exp_r[EXP_W-1:0], man_f[MW-2:0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READY    <= 1'b0;
            DATA_OUT <= '0;
        end else begin
            READY <= START;
            if (START) DATA_OUT <= result_c;
        end
    end

endmodule

// File: rtl/model_precedence_weighting.sv
// DNC precedence weighting update: p(t)[j] = (1 - sum_i w(t)[i]) * p(t-1)[j] + w(t)[j],
// streaming w(t) then p(t-1) through one shared adder and one multiplier.
module model_precedence_weighting
    import model_precedence_weighting_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned N_MAX        = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 W_IN_ENABLE,
    input  logic                 P_IN_ENABLE,
    output logic                 W_OUT_ENABLE,
    output logic                 P_IN_READY,
    output logic                 P_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] W_IN,
    input  logic [DATA_SIZE-1:0] P_IN,
    output logic [DATA_SIZE-1:0] P_OUT
);

    localparam int unsigned CW    = $clog2(N_MAX + 1);
    localparam int unsigned JW    = $clog2(N_MAX);
    localparam int unsigned EXP_W = float_exp_width(DATA_SIZE);
    localparam logic [DATA_SIZE-1:0] FLOAT_ONE = (DATA_SIZE == 64) ? DATA_SIZE'(FLOAT_ONE_64)
        : {2'b00, {(EXP_W-1){1'b1}}, {(DATA_SIZE-EXP_W-1){1'b0}}};

    state_t                  state;
    logic [CW-1:0]           n, n_c;
    logic [JW-1:0]           j;
    logic                    last_c, done_pending;
    logic [DATA_SIZE-1:0]    acc, scale;
    logic [DATA_SIZE-1:0]    w_buf [N_MAX];
    logic [DATA_SIZE-1:0]    add_a, add_b, add_out, mul_a, mul_b, mul_out;
    logic [CONTROL_SIZE-1:0] add_op;
    logic                    add_start, add_ready, mul_start, mul_ready;

    assign n_c    = (SIZE_N_IN > DATA_SIZE'(N_MAX)) ? CW'(N_MAX) : CW'(SIZE_N_IN);
    assign last_c = (CW'(j) + CW'(1)) >= n;

    model_scalar_float_adder #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) u_adder (
        .CLK       (CLK),
        .RST       (RST),
        .START     (add_start),
        .OPERATION (add_op),
        .DATA_A_IN (add_a),
        .DATA_B_IN (add_b),
        .READY     (add_ready),
        .DATA_OUT  (add_out)
    );

    model_scalar_float_multiplier #(
        .DATA_SIZE (DATA_SIZE)
    ) u_multiplier (
        .CLK       (CLK),
        .RST       (RST),
        .START     (mul_start),
        .DATA_A_IN (mul_a),
        .DATA_B_IN (mul_b),
        .READY     (mul_ready),
        .DATA_OUT  (mul_out)
    );

    // w(t) is needed again in the p phase, so keep a copy per element.
    always_ff @(posedge CLK) begin
        if (state == W_INPUT && W_IN_ENABLE) w_buf[j] <= W_IN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= STARTER;
            n            <= '0;
            j            <= '0;
            acc          <= '0;
            scale        <= '0;
            add_a        <= '0;
            add_b        <= '0;
            add_op       <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            add_start    <= ZERO_DATA;
            mul_start    <= ZERO_DATA;
            done_pending <= ZERO_DATA;
            READY        <= ZERO_DATA;
            W_OUT_ENABLE <= ZERO_DATA;
            P_IN_READY   <= ZERO_DATA;
            P_OUT_ENABLE <= ZERO_DATA;
            P_OUT        <= '0;
        end else begin
            READY        <= done_pending;
            done_pending <= ZERO_DATA;
            W_OUT_ENABLE <= ZERO_DATA;
            P_IN_READY   <= ZERO_DATA;
            P_OUT_ENABLE <= ZERO_DATA;
            add_start    <= ZERO_DATA;
            mul_start    <= ZERO_DATA;

            case (state)
                STARTER: begin
                    if (START) begin
                        n   <= n_c;
                        j   <= '0;
                        acc <= '0;
                        if (n_c == '0) READY <= ONE_DATA;
                        else           state <= W_INPUT;
                    end
                end
                W_INPUT: begin
                    if (W_IN_ENABLE) begin
                        add_a     <= acc;
                        add_b     <= W_IN;
                        add_op    <= CONTROL_SIZE'(OP_ADD);
                        add_start <= ONE_DATA;
                        state     <= W_ADD;
                    end
                end
                W_ADD: begin
                    if (add_ready) begin
                        acc <= add_out;
                        if (!last_c) begin
                            j            <= j + JW'(1);
                            W_OUT_ENABLE <= ONE_DATA;
                            state        <= W_INPUT;
                        end else begin
                            // Issue ONE - acc on the way into SCALE.
                            add_a     <= FLOAT_ONE;
                            add_b     <= add_out;
                            add_op    <= CONTROL_SIZE'(OP_SUB);
                            add_start <= ONE_DATA;
                            state     <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    if (add_ready) begin
                        scale <= add_out;
                        j     <= '0;
                        state <= P_INPUT;
                    end
                end
                P_INPUT: begin
                    if (P_IN_ENABLE) begin
                        mul_a     <= scale;
                        mul_b     <= P_IN;
                        mul_start <= ONE_DATA;
                        state     <= P_MUL;
                    end
                end
                P_MUL: begin
                    if (mul_ready) begin
                        add_a     <= mul_out;
                        add_b     <= w_buf[j];
                        add_op    <= CONTROL_SIZE'(OP_ADD);
                        add_start <= ONE_DATA;
                        state     <= P_ADD;
                    end
                end
                P_ADD: begin
                    if (add_ready) begin
                        P_OUT        <= add_out;
                        P_OUT_ENABLE <= ONE_DATA;
                        if (!last_c) begin
                            j          <= j + JW'(1);
                            P_IN_READY <= ONE_DATA;
                            state      <= P_INPUT;
                        end else begin
                            done_pending <= ONE_DATA;
                            state        <= STARTER;
                        end
                    end
                end
                default: state <= STARTER;
            endcase
        end
    end

endmodule

// File: tb/tb_model_precedence_weighting.sv
// Scoreboard bench: each update pushes reference p(t) values computed with real
// arithmetic; a negedge monitor pops and compares on every P_OUT_ENABLE strobe.
module tb_model_precedence_weighting;
    import model_precedence_weighting_pkg::*;

    localparam int unsigned DS = 64;
    localparam int NM = 16;

    logic          CLK = 1'b0;
    logic          RST, START, READY, W_IN_ENABLE, P_IN_ENABLE;
    logic          W_OUT_ENABLE, P_IN_READY, P_OUT_ENABLE;
    logic [DS-1:0] SIZE_N_IN, W_IN, P_IN, P_OUT;

    int checks = 0;
    int errors = 0;
    int n_ready = 0, n_wout = 0, n_pinr = 0, n_pout = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    real w_arr[40];
    real p_arr[40];

    model_precedence_weighting #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (64),
        .N_MAX        (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .READY        (READY),
        .W_IN_ENABLE  (W_IN_ENABLE),
        .P_IN_ENABLE  (P_IN_ENABLE),
        .W_OUT_ENABLE (W_OUT_ENABLE),
        .P_IN_READY   (P_IN_READY),
        .P_OUT_ENABLE (P_OUT_ENABLE),
        .SIZE_N_IN    (SIZE_N_IN),
        .W_IN         (W_IN),
        .P_IN         (P_IN),
        .P_OUT        (P_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Monitor: strobe counting and scoreboard comparison of P_OUT.
    always @(negedge CLK) begin
        if (!RST) begin
            if (READY)        n_ready++;
            if (W_OUT_ENABLE) n_wout++;
            if (P_IN_READY)   n_pinr++;
            if (P_OUT_ENABLE) begin
                n_pout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL p_out_unexpected actual=%0h expected=none", P_OUT);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (P_OUT !== mon_exp) begin
                        errors++;
                        $display("FAIL p_out actual=%0h expected=%0h", P_OUT, mon_exp);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},  64'(READY), 64'd0);
        check({tag, "_wout"},   64'(W_OUT_ENABLE), 64'd0);
        check({tag, "_pinr"},   64'(P_IN_READY), 64'd0);
        check({tag, "_pouten"}, 64'(P_OUT_ENABLE), 64'd0);
        check({tag, "_pout"},   P_OUT, 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 40; i++) begin
            w_arr[i] = real'($urandom_range(0, 255)) / 256.0;
            p_arr[i] = real'($urandom_range(0, 256)) / 256.0;
        end
    endtask

    // One update: reference model, then drive the w/p streams until READY.
    task automatic run_update(input int size_n, input bit gaps, input bit restart_mid, input bit abort_pmul);
        int n, wi, pi, cyc, r0, w0, p0, o0;
        bit done, aborted;
        real acc, s;
        n = (size_n > NM) ? NM : size_n;
        acc = 0.0;
        for (int i = 0; i < n; i++) acc = acc + w_arr[i];
        s = 1.0 - acc;
        for (int i = 0; i < n; i++) exp_q.push_back($realtobits(s * p_arr[i] + w_arr[i]));
        r0 = n_ready; w0 = n_wout; p0 = n_pinr; o0 = n_pout;

        @(negedge CLK);
        wi = 0; pi = 0; cyc = 0; done = 0; aborted = 0;
        W_IN = $realtobits(w_arr[0]);
        P_IN = $realtobits(p_arr[0]);
        W_IN_ENABLE = 1'b1;
        P_IN_ENABLE = 1'b1;
        SIZE_N_IN = DS'(size_n);
        START = 1'b1;
        while (!done && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            START = restart_mid && (cyc == 4);
            if (READY) begin
                done = 1;
                if (size_n == 0) check("n0_latency", 64'(cyc), 64'd1);
            end
            if (abort_pmul && !done && dut.state == P_MUL) begin
                #2 RST = 1'b1;
                #1 check_outputs_zero("abort");
                exp_q.delete();
                @(negedge CLK);
                RST = 1'b0;
                repeat (3) @(negedge CLK);
                #1 check("abort_no_ready", 64'(n_ready - r0), 64'd0);
                check("abort_pout_hold", P_OUT, 64'd0);
                aborted = 1;
                done = 1;
            end
            if (W_OUT_ENABLE && wi < 39) wi++;
            if (P_IN_READY && pi < 39) pi++;
            W_IN = $realtobits(w_arr[wi]);
            P_IN = $realtobits(p_arr[pi]);
            W_IN_ENABLE = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            P_IN_ENABLE = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        START = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL update_timeout actual=no_ready expected=ready size=%0d", size_n);
        end
        if (abort_pmul && !aborted) check("abort_reached", 64'd0, 64'd1);
        @(negedge CLK);
        #1;
        if (!aborted) begin
            check("ready_count", 64'(n_ready - r0), 64'd1);
            check("wout_count",  64'(n_wout - w0), 64'((n > 0) ? n - 1 : 0));
            check("pinr_count",  64'(n_pinr - p0), 64'((n > 0) ? n - 1 : 0));
            check("pout_count",  64'(n_pout - o0), 64'(n));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
        end
        W_IN_ENABLE = 1'b0;
        P_IN_ENABLE = 1'b0;
    endtask

    task automatic load_case1();
        w_arr[0] = 0.25; w_arr[1] = 0.5;
        p_arr[0] = 0.5;  p_arr[1] = 0.5;
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        W_IN_ENABLE = 1'b0;
        P_IN_ENABLE = 1'b0;
        SIZE_N_IN = '0;
        W_IN = '0;
        P_IN = '0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        load_case1();
        run_update(2, 0, 0, 0);
        check("case1_last_pout", P_OUT, 64'h3FE4000000000000);

        w_arr[0] = 0.0;   w_arr[1] = 0.0;  w_arr[2] = 0.0;
        p_arr[0] = 0.125; p_arr[1] = 0.25; p_arr[2] = 0.5;
        run_update(3, 0, 0, 0);

        w_arr[0] = 1.0; p_arr[0] = 0.75;
        run_update(1, 0, 0, 0);
        check("case3_pout", P_OUT, 64'h3FF0000000000000);

        run_update(0, 0, 0, 0);

        fill_random();
        run_update(40, 1, 0, 0);

        fill_random();
        run_update(5, 0, 1, 0);

        load_case1();
        run_update(2, 0, 0, 1);
        run_update(2, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            fill_random();
            run_update(int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/model_precedence_weighting.md
Name: model_precedence_weighting

Overview:
- DNC memory stage computing the precedence weighting p(t)[j] = (1 - sum_i w(t)[i])·p(t-1)[j] + w(t)[j], with p(t=0) = 0.
- Sits directly upstream of the temporal link matrix block, which consumes P_OUT as p(t-1) on its next update.
- Streams w(t), then p(t-1), element by element. Arithmetic uses the existing scalar float adder and multiplier units (IEEE-754, DATA_SIZE bits).

Parameters:
- DATA_SIZE, 64, scalar width; IEEE-754 binary64 when 64.
- CONTROL_SIZE, 64, passed through to the float units.
- N_MAX, 16, depth of the internal w buffer (maximum N).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset: asynchronous, active-high.
- START  in  1  begin one update; sampled in STARTER only.
- READY  out  1  one-cycle pulse when the update completes.
- W_IN_ENABLE  in  1  W_IN valid.
- P_IN_ENABLE  in  1  P_IN valid.
- W_OUT_ENABLE  out  1  one-cycle pulse: w element consumed, block waiting for the next one.
- P_IN_READY  out  1  one-cycle pulse: p element consumed, block waiting for the next one.
- P_OUT_ENABLE  out  1  one-cycle strobe: P_OUT valid.
- SIZE_N_IN  in  DATA_SIZE  vector length N (integer).
- W_IN  in  DATA_SIZE  w(t)[j], float.
- P_IN  in  DATA_SIZE  p(t-1)[j], float.
- P_OUT  out  DATA_SIZE  p(t)[j], float.

Behaviour:
- Reset: whenever RST=1, asynchronously force all of the following, aborting any update with no READY:
  - outputs: all 0;
  - FSM: STARTER;
  - counter: 0; accumulator: +0.0; sub-unit STARTs: 0.
- STARTER: on START=1, latch N = min(SIZE_N_IN, N_MAX) and set acc = 0.0.
  - N=0: READY pulses the next cycle, with no other output activity.
  - N>0: go to W_INPUT.
- W_INPUT: wait for W_IN_ENABLE=1, then store W_IN into buf[j] and start the adder with OPERATION=0, acc + W_IN. Go to W_ADD.
- W_ADD: on adder READY, acc <= sum.
  - j<N-1: j++, pulse W_OUT_ENABLE, return to W_INPUT.
  - Otherwise: go to SCALE.
- SCALE: start the adder with OPERATION=1, ONE - acc, where ONE = 0x3FF0000000000000 for 64 bits. On READY, store s, set j=0, go to P_INPUT.
- P_INPUT: wait for P_IN_ENABLE=1, then start the multiplier on s·P_IN. Go to P_MUL.
- P_MUL: on multiplier READY, start the adder on product + buf[j]. Go to P_ADD.
- P_ADD: on adder READY:
  - P_OUT <= sum; P_OUT_ENABLE pulses 1 cycle.
  - j<N-1: j++, pulse P_IN_READY, return to P_INPUT.
  - Otherwise: READY pulses 1 cycle later, return to STARTER.
- Input sampling:
  - X_IN_ENABLE is ignored outside the matching wait state.
  - A held-high enable consumes exactly one element per visit to that wait state.
- START asserted while not in STARTER is ignored.
- Sub-unit START is a single-cycle pulse. Sub-unit DATA inputs are held registered until the unit's READY.
- P_OUT holds its last value between strobes.
- Latency is data-dependent on sub-unit latency. No fixed cycle count is required beyond the ordering above.

Decomposition:
- Shared DNC package holds:
  - FSM state encodings: STARTER, W_INPUT, W_ADD, SCALE, P_INPUT, P_MUL, P_ADD;
  - ZERO_DATA / ONE_DATA and the float ONE constant;
  - the adder OPERATION codes (ADD=0, SUB=1).
- Instantiate model_scalar_float_adder once, shared by the W_ADD, SCALE and P_ADD phases through a muxed operand register.
- Instantiate model_scalar_float_multiplier once.
- The w buffer is an inline register array; no separate sub-module.

Test Plan:
- N=2, w=[0.25,0.5], p=[0.5,0.5] -> s=0.25; P_OUT=0x3FD8000000000000 (0.375), then 0x3FE4000000000000 (0.625). Exactly 2 P_OUT_ENABLE strobes, 1 W_OUT_ENABLE, 1 P_IN_READY, then READY.
- N=3, w=[0,0,0], p=[0.125,0.25,0.5] -> p passes through unchanged; READY once.
- N=1, w=[1.0], p=[0.75] -> s=0; P_OUT=0x3FF0000000000000; no W_OUT_ENABLE or P_IN_READY pulses.
- SIZE_N_IN=0 -> READY one cycle after START; no enables; SIZE_N_IN=40 with N_MAX=16 -> exactly 16 outputs.
- W_IN_ENABLE held high, START re-pulsed mid-update -> one element consumed per W_OUT_ENABLE; second START ignored; outputs match the first update.
- RST pulsed during P_MUL -> all outputs 0 immediately and no READY. A fresh START then produces correct results from acc=0.
